// File: rtl/axi_common.sv
// Shared AXI-Lite field types, response codes and the data-width legality check.
package axi_common;

   typedef logic [2:0] prot_t;
   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;

   function automatic bit axi_lite_data_width_ok(int width, bit relax);
      if (relax) begin
         return (width >= 8) && ((width % 8) == 0);
      end
      return (width == 32) || (width == 64);
   endfunction

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite five-channel bundle; the master modport drives requests, the slave modport responses.
interface axi_lite_channel
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();
   import axi_common::*;

   logic                    aw_valid;
   logic                    aw_ready;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   prot_t                   aw_prot;

   logic                    w_valid;
   logic                    w_ready;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;

   logic                    b_valid;
   logic                    b_ready;
   resp_t                   b_resp;

   logic                    ar_valid;
   logic                    ar_ready;
   logic [ADDR_WIDTH-1:0]   ar_addr;
   prot_t                   ar_prot;

   logic                    r_valid;
   logic                    r_ready;
   logic [DATA_WIDTH-1:0]   r_data;
   resp_t                   r_resp;

   modport master (
      output aw_valid, aw_addr, aw_prot, input aw_ready,
      output w_valid, w_data, w_strb, input w_ready,
      input b_valid, b_resp, output b_ready,
      output ar_valid, ar_addr, ar_prot, input ar_ready,
      input r_valid, r_data, r_resp, output r_ready
   );

   modport slave (
      input aw_valid, aw_addr, aw_prot, output aw_ready,
      input w_valid, w_data, w_strb, output w_ready,
      output b_valid, b_resp, input b_ready,
      input ar_valid, ar_addr, ar_prot, output ar_ready,
      output r_valid, r_data, r_resp, input r_ready
   );

endinterface

// File: rtl/axi_fifo.sv
// Valid/ready FIFO with registered output; DEPTH 0 degenerates to a plain wire-through.
module axi_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             empty
);

   if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;

      assign out_valid      = in_valid;
      assign in_ready       = out_ready;
      assign out_data       = in_data;
      assign empty          = 1'b1;
      assign unused_clk_rst = clk ^ rstn;
   end else begin : g_fifo
      localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam int CNT_W = $clog2(DEPTH + 1);
      localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
      localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
      logic [CNT_W-1:0] count_q;
      logic             push, pop;

      // Ready depends only on stored count, so a full FIFO cannot accept in the cycle it pops.
      assign in_ready  = rstn && (count_q != FULL_CNT);
      assign out_valid = (count_q != '0);
      assign out_data  = mem_q[rd_ptr_q];
      assign empty     = (count_q == '0);
      assign push      = in_valid && in_ready;
      assign pop       = out_valid && out_ready;

      always_ff @(posedge clk) begin
         if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
               count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
               count_q <= count_q - CNT_W'(1);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (push) begin
            mem_q[wr_ptr_q] <= in_data;
         end
      end
   end

endmodule

// File: rtl/axi_lite_buffer.sv
// AXI-Lite register slice: one independently sized FIFO per channel plus a registered idle flag.
module axi_lite_buffer
   import axi_common::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int RELAX_CHECK = 0,
   parameter int AW_DEPTH    = 2,
   parameter int W_DEPTH     = 2,
   parameter int B_DEPTH     = 2,
   parameter int AR_DEPTH    = 2,
   parameter int R_DEPTH     = 2
) (
   input  logic             clk,
   input  logic             rstn,
   axi_lite_channel.slave   slave,
   axi_lite_channel.master  master,
   output logic             idle
);

   if (slave.ADDR_WIDTH != ADDR_WIDTH || master.ADDR_WIDTH != ADDR_WIDTH ||
       slave.DATA_WIDTH != DATA_WIDTH || master.DATA_WIDTH != DATA_WIDTH) begin : g_bad_iface
      $fatal(1, "axi_lite_buffer: interface width does not match parameters");
   end
   if (!axi_lite_data_width_ok(DATA_WIDTH, RELAX_CHECK != 0)) begin : g_bad_data_width
      $fatal(1, "axi_lite_buffer: illegal DATA_WIDTH %0d", DATA_WIDTH);
   end
   if (AW_DEPTH < 0 || W_DEPTH < 0 || B_DEPTH < 0 || AR_DEPTH < 0 || R_DEPTH < 0)
   begin : g_bad_depth
      $fatal(1, "axi_lite_buffer: negative FIFO depth");
   end

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      prot_t                 prot;
   } ax_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]   data;
      logic [DATA_WIDTH/8-1:0] strb;
   } w_t;

   typedef struct packed {
      resp_t resp;
   } b_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      resp_t                 resp;
   } r_t;

   ax_t        aw_in, aw_out, ar_in, ar_out;
   w_t         w_in, w_out;
   b_t         b_in, b_out;
   r_t         r_in, r_out;
   logic [4:0] empty;

   assign aw_in          = '{addr: slave.aw_addr, prot: slave.aw_prot};
   assign master.aw_addr = aw_out.addr;
   assign master.aw_prot = aw_out.prot;
   assign w_in           = '{data: slave.w_data, strb: slave.w_strb};
   assign master.w_data  = w_out.data;
   assign master.w_strb  = w_out.strb;
   assign b_in           = '{resp: master.b_resp};
   assign slave.b_resp   = b_out.resp;
   assign ar_in          = '{addr: slave.ar_addr, prot: slave.ar_prot};
   assign master.ar_addr = ar_out.addr;
   assign master.ar_prot = ar_out.prot;
   assign r_in           = '{data: master.r_data, resp: master.r_resp};
   assign slave.r_data   = r_out.data;
   assign slave.r_resp   = r_out.resp;

   axi_fifo #(.WIDTH($bits(ax_t)), .DEPTH(AW_DEPTH)) u_aw_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (slave.aw_valid),
      .in_ready  (slave.aw_ready),
      .in_data   (aw_in),
      .out_valid (master.aw_valid),
      .out_ready (master.aw_ready),
      .out_data  (aw_out),
      .empty     (empty[0])
   );

   axi_fifo #(.WIDTH($bits(w_t)), .DEPTH(W_DEPTH)) u_w_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (slave.w_valid),
      .in_ready  (slave.w_ready),
      .in_data   (w_in),
      .out_valid (master.w_valid),
      .out_ready (master.w_ready),
      .out_data  (w_out),
      .empty     (empty[1])
   );

   axi_fifo #(.WIDTH($bits(b_t)), .DEPTH(B_DEPTH)) u_b_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (master.b_valid),
      .in_ready  (master.b_ready),
      .in_data   (b_in),
      .out_valid (slave.b_valid),
      .out_ready (slave.b_ready),
      .out_data  (b_out),
      .empty     (empty[2])
   );

   axi_fifo #(.WIDTH($bits(ax_t)), .DEPTH(AR_DEPTH)) u_ar_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (slave.ar_valid),
      .in_ready  (slave.ar_ready),
      .in_data   (ar_in),
      .out_valid (master.ar_valid),
      .out_ready (master.ar_ready),
      .out_data  (ar_out),
      .empty     (empty[3])
   );

   axi_fifo #(.WIDTH($bits(r_t)), .DEPTH(R_DEPTH)) u_r_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (master.r_valid),
      .in_ready  (master.r_ready),
      .in_data   (r_in),
      .out_valid (slave.r_valid),
      .out_ready (slave.r_ready),
      .out_data  (r_out),
      .empty     (empty[4])
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         idle <= 1'b1;
      end else begin
         idle <= &empty;
      end
   end

endmodule

// File: tb/tb_axi_lite_buffer.sv
// Randomized and directed bench for axi_lite_buffer against a queue-per-channel reference model.
module tb_axi_lite_buffer;
   import axi_common::*;

   localparam int AW_D = 2;
   localparam int W_D  = 2;
   localparam int B_D  = 0;
   localparam int AR_D = 3;
   localparam int R_D  = 1;

   logic clk = 1'b0;
   logic rstn;
   logic idle;

   always #5 clk = ~clk;

   axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) up_if ();
   axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dn_if ();

   axi_lite_buffer #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .RELAX_CHECK (0),
      .AW_DEPTH    (AW_D),
      .W_DEPTH     (W_D),
      .B_DEPTH     (B_D),
      .AR_DEPTH    (AR_D),
      .R_DEPTH     (R_D)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .slave  (up_if),
      .master (dn_if),
      .idle   (idle)
   );

   // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R. "in" is the producing side, "out" the consuming side.
   logic [4:0]  iv, ordy, irdy, out_v, acc_in;
   logic [35:0] id    [5];
   logic [35:0] out_d [5];

   assign up_if.aw_valid = iv[0];
   assign up_if.aw_addr  = id[0][34:3];
   assign up_if.aw_prot  = id[0][2:0];
   assign up_if.w_valid  = iv[1];
   assign up_if.w_data   = id[1][35:4];
   assign up_if.w_strb   = id[1][3:0];
   assign dn_if.b_valid  = iv[2];
   assign dn_if.b_resp   = id[2][1:0];
   assign up_if.ar_valid = iv[3];
   assign up_if.ar_addr  = id[3][34:3];
   assign up_if.ar_prot  = id[3][2:0];
   assign dn_if.r_valid  = iv[4];
   assign dn_if.r_data   = id[4][33:2];
   assign dn_if.r_resp   = id[4][1:0];

   assign dn_if.aw_ready = ordy[0];
   assign dn_if.w_ready  = ordy[1];
   assign up_if.b_ready  = ordy[2];
   assign dn_if.ar_ready = ordy[3];
   assign up_if.r_ready  = ordy[4];

   assign irdy  = {dn_if.r_ready, up_if.ar_ready, dn_if.b_ready, up_if.w_ready, up_if.aw_ready};
   assign out_v = {up_if.r_valid, dn_if.ar_valid, up_if.b_valid, dn_if.w_valid, dn_if.aw_valid};
   assign out_d[0] = {1'b0, dn_if.aw_addr, dn_if.aw_prot};
   assign out_d[1] = {dn_if.w_data, dn_if.w_strb};
   assign out_d[2] = {34'd0, up_if.b_resp};
   assign out_d[3] = {1'b0, dn_if.ar_addr, dn_if.ar_prot};
   assign out_d[4] = {2'd0, up_if.r_data, up_if.r_resp};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int depth_of(int c);
      case (c)
         0: return AW_D;
         1: return W_D;
         2: return B_D;
         3: return AR_D;
         default: return R_D;
      endcase
   endfunction

   function automatic logic [35:0] mask_of(int c);
      case (c)
         0, 3: return 36'h7_FFFF_FFFF;
         1: return 36'hF_FFFF_FFFF;
         2: return 36'h0_0000_0003;
         default: return 36'h3_FFFF_FFFF;
      endcase
   endfunction

   // Reference model: each buffered channel is an ordered queue; an entry accepted
   // at an edge is visible from the next cycle on.
   logic [35:0] mq [5][$];
   int          hs_in  [5][$];
   int          hs_out [5][$];
   int          cyc = 0;
   logic        exp_idle = 1'b1;
   logic        prev_rst = 1'b0;

   always @(negedge clk) begin : model
      int   sz;
      logic ev, er, ao, all_empty;
      cyc++;
      if (!rstn) begin
         for (int c = 0; c < 5; c++) begin
            acc_in[c] = 1'b0;
            if (depth_of(c) == 0) begin
               check_eq($sformatf("rst_pt_valid[%0d]", c), out_v[c], iv[c]);
               check_eq($sformatf("rst_pt_ready[%0d]", c), irdy[c], ordy[c]);
            end else begin
               check_eq($sformatf("rst_in_ready[%0d]", c), irdy[c], 1'b0);
               if (prev_rst) check_eq($sformatf("rst_out_valid[%0d]", c), out_v[c], 1'b0);
            end
            mq[c].delete();
         end
         if (prev_rst) check_eq("rst_idle", idle, 1'b1);
         exp_idle = 1'b1;
         prev_rst = 1'b1;
      end else begin
         all_empty = 1'b1;
         for (int c = 0; c < 5; c++) begin
            if (depth_of(c) == 0) begin
               check_eq($sformatf("pt_valid[%0d]", c), out_v[c], iv[c]);
               check_eq($sformatf("pt_ready[%0d]", c), irdy[c], ordy[c]);
               if (iv[c]) check_eq($sformatf("pt_data[%0d]", c), out_d[c], id[c]);
               acc_in[c] = iv[c] && ordy[c];
               ao = acc_in[c];
            end else begin
               sz = mq[c].size();
               ev = (sz != 0);
               er = (sz != depth_of(c));
               check_eq($sformatf("in_ready[%0d]", c), irdy[c], er);
               check_eq($sformatf("out_valid[%0d]", c), out_v[c], ev);
               if (ev) check_eq($sformatf("out_data[%0d]", c), out_d[c], mq[c][0]);
               if (ev) all_empty = 1'b0;
               ao = ev && ordy[c];
               acc_in[c] = iv[c] && er;
               if (ao) void'(mq[c].pop_front());
               if (acc_in[c]) mq[c].push_back(id[c]);
            end
            if (acc_in[c]) hs_in[c].push_back(cyc);
            if (ao) hs_out[c].push_back(cyc);
         end
         check_eq("idle", idle, exp_idle);
         exp_idle = all_empty;
         prev_rst = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic drain();
      iv   = '0;
      ordy = '1;
      repeat (6) step();
      for (int c = 0; c < 5; c++) begin
         hs_in[c].delete();
         hs_out[c].delete();
      end
   endtask

   task automatic drive_rand(input int pv, input int pr);
      logic [63:0] r;
      for (int c = 0; c < 5; c++) begin
         if (!(iv[c] && !acc_in[c])) begin
            r     = {$urandom(), $urandom()};
            iv[c] = ($urandom_range(99) < pv);
            id[c] = r[35:0] & mask_of(c);
         end
         ordy[c] = ($urandom_range(99) < pr);
      end
   endtask

   initial begin : stim
      int n;
      int guard;
      rstn = 1'b0;
      iv   = 5'b00001;
      ordy = '0;
      for (int c = 0; c < 5; c++) id[c] = '0;
      id[0] = {1'b0, 32'h0000_1000, 3'b000};

      // Reset held 3 cycles with AW valid asserted upstream.
      repeat (3) step();
      sample();
      check_eq("rst_hold_aw_valid", out_v[0], 1'b0);
      check_eq("rst_hold_aw_ready", irdy[0], 1'b0);
      check_eq("rst_hold_idle", idle, 1'b1);
      step();
      rstn = 1'b1;
      sample();
      check_eq("post_rst_aw_ready", irdy[0], 1'b1);
      step();
      iv[0] = 1'b0;
      drain();

      // AW streaming: 8 back-to-back beats.
      n = 0;
      guard = 0;
      iv[0] = 1'b1;
      id[0] = {1'b0, 32'h0, 3'b000};
      while (n < 8 && guard < 40) begin
         step();
         guard++;
         if (acc_in[0]) begin
            n++;
            if (n < 8) id[0] = {1'b0, 32'(n * 4), 3'b000};
            else iv[0] = 1'b0;
         end
      end
      check_eq("stream_sent", n, 8);
      repeat (4) step();
      check_eq("stream_out_count", hs_out[0].size(), 8);
      if (hs_out[0].size() == 8 && hs_in[0].size() == 8) begin
         check_eq("stream_no_bubbles", hs_out[0][7] - hs_out[0][0], 7);
         check_eq("stream_latency", hs_out[0][0] - hs_in[0][0], 1);
      end
      drain();

      // W backpressure: two beats fill the FIFO, third waits.
      ordy[1] = 1'b0;
      iv[1]   = 1'b1;
      id[1]   = {32'hA5A5_A5A5, 4'hF};
      n = 0;
      guard = 0;
      while (n < 2 && guard < 20) begin
         step();
         guard++;
         if (acc_in[1]) begin
            n++;
            if (n == 1) id[1] = {32'h5A5A_5A5A, 4'h3};
            else id[1] = {32'h1234_5678, 4'h5};
         end
      end
      check_eq("bp_accepted", n, 2);
      repeat (4) step();
      sample();
      check_eq("bp_w_ready_full", irdy[1], 1'b0);
      check_eq("bp_stall_data", out_d[1], {32'hA5A5_A5A5, 4'hF});
      step();
      ordy[1] = 1'b1;
      repeat (8) begin
         step();
         if (acc_in[1]) iv[1] = 1'b0;
      end
      check_eq("bp_delivered", hs_out[1].size(), 3);
      drain();

      // Depth-1 R: continuous valid gives one beat every other cycle.
      ordy[4] = 1'b1;
      iv[4]   = 1'b1;
      id[4]   = {2'd0, 32'hC0DE_0000, RESP_OKAY};
      for (int i = 0; i < 10; i++) begin
         step();
         if (acc_in[4]) id[4] = {2'd0, 32'hC0DE_0000 + 32'(i), RESP_OKAY};
      end
      iv[4] = 1'b0;
      repeat (3) step();
      check_eq("r_beats", hs_out[4].size(), 5);
      for (int i = 1; i < hs_out[4].size(); i++) begin
         check_eq("r_spacing", hs_out[4][i] - hs_out[4][i-1], 2);
      end
      drain();

      // Depth-0 B: ready and valid pass straight through.
      ordy[2] = 1'b0;
      iv[2]   = 1'b1;
      id[2]   = {34'd0, RESP_SLVERR};
      sample();
      check_eq("b_pt_ready_low", irdy[2], 1'b0);
      check_eq("b_pt_valid", out_v[2], 1'b1);
      check_eq("b_pt_resp", out_d[2], {34'd0, RESP_SLVERR});
      step();
      ordy[2] = 1'b1;
      sample();
      check_eq("b_pt_ready_high", irdy[2], 1'b1);
      drain();

      // AR reset with two buffered entries.
      ordy[3] = 1'b0;
      iv[3]   = 1'b1;
      id[3]   = {1'b0, 32'hDEAD_0000, 3'b010};
      n = 0;
      guard = 0;
      while (n < 2 && guard < 20) begin
         step();
         guard++;
         if (acc_in[3]) begin
            n++;
            if (n == 1) id[3] = {1'b0, 32'hDEAD_0004, 3'b010};
            else iv[3] = 1'b0;
         end
      end
      check_eq("ar_buffered", n, 2);
      rstn = 1'b0;
      step();
      rstn    = 1'b1;
      ordy[3] = 1'b1;
      hs_out[3].delete();
      sample();
      check_eq("ar_rst_valid", out_v[3], 1'b0);
      check_eq("ar_rst_idle", idle, 1'b1);
      repeat (5) step();
      check_eq("ar_no_stale", hs_out[3].size(), 0);
      drain();

      // Randomized traffic with varying load and one mid-run reset.
      for (int blk = 0; blk < 10; blk++) begin
         int pv, pr;
         pv = $urandom_range(100, 20);
         pr = $urandom_range(100, 20);
         if (blk == 5) begin
            rstn = 1'b0;
            repeat (2) step();
            rstn = 1'b1;
         end
         repeat (250) begin
            step();
            drive_rand(pv, pr);
         end
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation timeout");
   end

endmodule
